// File: rtl/f2c_dma_writer_pkg.sv
// f2c_dma_writer_pkg
//   Shared definitions for the FPGA->CPU DMA writer: register channel
//   numbers, TLP geometry, MWr header constants and the writer state enum.
package f2c_dma_writer_pkg;

  // Register channels carried on the host register-write path.
  localparam logic [6:0] F2C_BASE   = 7'h10;
  localparam logic [6:0] MTR_BASE   = 7'h11;
  localparam logic [6:0] DMA_ENABLE = 7'h12;
  localparam logic [6:0] F2C_RDPTR  = 7'h13;

  localparam int unsigned QWS_PER_TLP = 16;

  // MWr 3DW header DW0: data TLP carries 32 DWs, metrics TLP carries 2 DWs.
  localparam logic [31:0] MWR_DW0_DATA = 32'h4000_0020;
  localparam logic [31:0] MWR_DW0_MTR  = 32'h4000_0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DATA_H0,
    ST_DATA_H1,
    ST_DATA_D,
    ST_MTR_H0,
    ST_MTR_H1,
    ST_MTR_D
  } f2c_state_e;

  // First header beat {DW1, DW0}; DW1 = requester ID, tag 0, all byte enables.
  function automatic logic [63:0] mwr_hdr_beat(input logic [15:0] req_id,
                                               input logic [31:0] dw0);
    return {req_id, 8'h00, 8'hFF, dw0};
  endfunction

endpackage

// File: rtl/f2c_dma_writer_tlp_buffer.sv
// f2c_tlp_buffer
//   16 x 64-bit staging store for one data TLP payload. Writes append at
//   the fill counter; reads are registered (rd_data_o = mem[rd_addr_i] one
//   clock later).
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   clr_i             zero the fill counter (payload consumed or flushed)
//   wr_en_i/wr_data_i append one QW at position fill_o
//   rd_addr_i         read index, sampled every clock
//   rd_data_o         registered read data
//   fill_o            number of QWs stored (0..16)
module f2c_tlp_buffer
  import f2c_dma_writer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        wr_en_i,
  input  logic [63:0] wr_data_i,
  input  logic [3:0]  rd_addr_i,
  output logic [63:0] rd_data_o,
  output logic [4:0]  fill_o
);

  logic [63:0] mem_q [QWS_PER_TLP];
  logic [63:0] rd_data_q;
  logic [4:0]  fill_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[fill_q[3:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
      fill_q    <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
      if (clr_i)        fill_q <= '0;
      else if (wr_en_i) fill_q <= fill_q + 5'd1;
    end
  end

  assign rd_data_o = rd_data_q;
  assign fill_o    = fill_q;

endmodule

// File: rtl/f2c_dma_writer.sv
// f2c_dma_writer
//   FPGA->CPU DMA ring producer. Collects 16 app QWs, emits a 128-byte MWr
//   to ring slot wrPtr, then a 1-QW MWr of the new wrPtr to the metrics
//   buffer. The host returns its read pointer via F2C_RDPTR.
// Ports
//   pcieClk_in, reset_in                 clock, synchronous active-high reset
//   cpuChan_in/cpuWrData_in/cpuWrValid_in host register writes
//   f2cData_in/f2cValid_in/f2cReady_out  app QW stream
//   txData_out/txValid_out/txReady_in    TLP beats, txSOP_out/txEOP_out framing
//   tlpCount_out, stallCount_out          statistics (zero unless F2C_STATS_EN)
// Build option: define F2C_STATS_EN to include the statistics counters.
module f2c_dma_writer
  import f2c_dma_writer_pkg::*;
#(
  parameter int unsigned LOG2_SLOTS = 4,
  parameter logic [15:0] REQ_ID     = 16'h0108
) (
  input  logic        pcieClk_in,
  input  logic        reset_in,
  input  logic [6:0]  cpuChan_in,
  input  logic [31:0] cpuWrData_in,
  input  logic        cpuWrValid_in,
  input  logic [63:0] f2cData_in,
  input  logic        f2cValid_in,
  output logic        f2cReady_out,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  input  logic        txReady_in,
  output logic        txSOP_out,
  output logic        txEOP_out,
  output logic [31:0] tlpCount_out,
  output logic [31:0] stallCount_out
);

  f2c_state_e            state_q;
  logic [31:0]           f2cBase_q, mtrBase_q;
  logic                  enabled_q, clrPend_q;
  logic [LOG2_SLOTS-1:0] wrPtr_q, rdPtr_q;
  logic [3:0]            idx_q;
  logic [63:0]           txData_q;
  logic                  txValid_q, txSOP_q, txEOP_q;

  logic [4:0]  fill;
  logic [63:0] bufRdData;
  logic [3:0]  bufRdAddr_d;
  logic        txAccept, full, flush, lastData, bufWr, bufClr;
  logic [31:0] dataAddr, mtrAddr;

  assign txAccept = txValid_q & txReady_in;
  assign full     = (LOG2_SLOTS'(wrPtr_q + 1'b1) == rdPtr_q);
  assign flush    = clrPend_q && (state_q == ST_IDLE || state_q == ST_FILL);
  assign lastData = (state_q == ST_DATA_D) && txAccept && (idx_q == 4'(QWS_PER_TLP - 1));
  assign f2cReady_out = (state_q == ST_FILL) && enabled_q && !clrPend_q &&
                        (fill < 5'(QWS_PER_TLP));
  assign bufWr    = f2cValid_in & f2cReady_out;
  assign bufClr   = flush | lastData;
  assign dataAddr = (f2cBase_q + (32'(wrPtr_q) << 4)) << 3;
  assign mtrAddr  = mtrBase_q << 3;

  // Buffer read is registered while payload beats are registered too, so the
  // read index runs one beat ahead: rd_data always holds the next beat to load.
  always_comb begin
    bufRdAddr_d = '0;
    if (state_q == ST_DATA_H1)     bufRdAddr_d = txAccept ? 4'd1 : 4'd0;
    else if (state_q == ST_DATA_D) bufRdAddr_d = txAccept ? idx_q + 4'd2 : idx_q + 4'd1;
  end

  f2c_tlp_buffer u_buf (
    .clk_i     (pcieClk_in),
    .rst_i     (reset_in),
    .clr_i     (bufClr),
    .wr_en_i   (bufWr),
    .wr_data_i (f2cData_in),
    .rd_addr_i (bufRdAddr_d),
    .rd_data_o (bufRdData),
    .fill_o    (fill)
  );

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      f2cBase_q <= '0;
      mtrBase_q <= '0;
      enabled_q <= 1'b0;
      clrPend_q <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      idx_q     <= '0;
      txData_q  <= '0;
      txValid_q <= 1'b0;
      txSOP_q   <= 1'b0;
      txEOP_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            clrPend_q <= 1'b0;
          end else if (enabled_q) begin
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (flush) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            clrPend_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (fill == 5'(QWS_PER_TLP) && !full) begin
            txData_q  <= mwr_hdr_beat(REQ_ID, MWR_DW0_DATA);
            txValid_q <= 1'b1;
            txSOP_q   <= 1'b1;
            txEOP_q   <= 1'b0;
            state_q   <= ST_DATA_H0;
          end
        end
        ST_DATA_H0: if (txAccept) begin
          txData_q <= {32'h0, dataAddr};
          txSOP_q  <= 1'b0;
          state_q  <= ST_DATA_H1;
        end
        ST_DATA_H1: if (txAccept) begin
          txData_q <= bufRdData;
          idx_q    <= '0;
          state_q  <= ST_DATA_D;
        end
        ST_DATA_D: if (txAccept) begin
          if (idx_q == 4'(QWS_PER_TLP - 1)) begin
            wrPtr_q  <= wrPtr_q + 1'b1;
            txData_q <= mwr_hdr_beat(REQ_ID, MWR_DW0_MTR);
            txSOP_q  <= 1'b1;
            txEOP_q  <= 1'b0;
            state_q  <= ST_MTR_H0;
          end else begin
            txData_q <= bufRdData;
            idx_q    <= idx_q + 4'd1;
            txEOP_q  <= (idx_q == 4'(QWS_PER_TLP - 2));
          end
        end
        ST_MTR_H0: if (txAccept) begin
          txData_q <= {32'h0, mtrAddr};
          txSOP_q  <= 1'b0;
          state_q  <= ST_MTR_H1;
        end
        ST_MTR_H1: if (txAccept) begin
          // wrPtr_q already holds the post-increment slot here.
          txData_q <= {32'h0, 32'(wrPtr_q)};
          txEOP_q  <= 1'b1;
          state_q  <= ST_MTR_D;
        end
        ST_MTR_D: if (txAccept) begin
          txValid_q <= 1'b0;
          txEOP_q   <= 1'b0;
          state_q   <= enabled_q ? ST_FILL : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Register writes come last so a write in a flush cycle is kept.
      if (cpuWrValid_in) begin
        case (cpuChan_in)
          F2C_BASE:  f2cBase_q <= cpuWrData_in;
          MTR_BASE:  mtrBase_q <= cpuWrData_in;
          F2C_RDPTR: rdPtr_q   <= cpuWrData_in[LOG2_SLOTS-1:0];
          DMA_ENABLE: begin
            enabled_q <= cpuWrData_in[0];
            if (!cpuWrData_in[0]) clrPend_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign txData_out  = txData_q;
  assign txValid_out = txValid_q;
  assign txSOP_out   = txSOP_q;
  assign txEOP_out   = txEOP_q;

`ifdef F2C_STATS_EN
  logic [31:0] tlpCount_q, stallCount_q;

  always_ff @(posedge pcieClk_in) begin
    if (reset_in || flush) begin
      tlpCount_q   <= '0;
      stallCount_q <= '0;
    end else begin
      if (lastData) tlpCount_q <= tlpCount_q + 32'd1;
      if (state_q == ST_FILL && fill == 5'(QWS_PER_TLP) && full)
        stallCount_q <= stallCount_q + 32'd1;
    end
  end

  assign tlpCount_out   = tlpCount_q;
  assign stallCount_out = stallCount_q;
`else
  assign tlpCount_out   = '0;
  assign stallCount_out = '0;
`endif

endmodule

// File: tb/tb_f2c_dma_writer.sv
module tb_f2c_dma_writer;
  import f2c_dma_writer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [6:0]  cpuChan_in = '0;
  logic [31:0] cpuWrData_in = '0;
  logic        cpuWrValid_in = 1'b0;
  logic [63:0] f2cData_in = '0;
  logic        f2cValid_in = 1'b0;
  logic        f2cReady_out;
  logic [63:0] txData_out;
  logic        txValid_out;
  logic        txReady_in = 1'b1;
  logic        txSOP_out, txEOP_out;
  logic [31:0] tlpCount_out, stallCount_out;

  always #5 clk = ~clk;

  f2c_dma_writer #(.LOG2_SLOTS(4), .REQ_ID(16'h0108)) dut (
    .pcieClk_in     (clk),
    .reset_in       (reset_in),
    .cpuChan_in     (cpuChan_in),
    .cpuWrData_in   (cpuWrData_in),
    .cpuWrValid_in  (cpuWrValid_in),
    .f2cData_in     (f2cData_in),
    .f2cValid_in    (f2cValid_in),
    .f2cReady_out   (f2cReady_out),
    .txData_out     (txData_out),
    .txValid_out    (txValid_out),
    .txReady_in     (txReady_in),
    .txSOP_out      (txSOP_out),
    .txEOP_out      (txEOP_out),
    .tlpCount_out   (tlpCount_out),
    .stallCount_out (stallCount_out)
  );

  int unsigned nCmp = 0;
  int unsigned nErr = 0;
  logic [65:0] beats_q[$];
  int unsigned feedRemain = 0;
  logic [63:0] nextQW = '0;
  logic        bpMode = 1'b0;
  logic        stallPrev = 1'b0;
  logic [65:0] prevVec = '0;
  logic [31:0] s1;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are set at the falling edge and held to the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (stallPrev === 1'b1) begin
      chk("hold_valid", 66'(txValid_out), 66'd1);
      chk("hold_beat", {txSOP_out, txEOP_out, txData_out}, prevVec);
    end
    txReady_in  = bpMode ? ($urandom_range(0, 1) == 1) : 1'b1;
    f2cValid_in = (feedRemain > 0);
    f2cData_in  = nextQW;
    if (f2cValid_in && f2cReady_out === 1'b1) begin
      feedRemain--;
      nextQW++;
    end
    if (txValid_out === 1'b1 && txReady_in)
      beats_q.push_back({txSOP_out, txEOP_out, txData_out});
    stallPrev = txValid_out && !txReady_in;
    prevVec   = {txSOP_out, txEOP_out, txData_out};
  endtask

  task automatic wr_reg(input logic [6:0] ch, input logic [31:0] d);
    cpuChan_in    = ch;
    cpuWrData_in  = d;
    cpuWrValid_in = 1'b1;
    cycle();
    cpuWrValid_in = 1'b0;
  endtask

  task automatic wait_beats(input int unsigned n, input string tag);
    int unsigned budget = 0;
    while (beats_q.size() < n && budget < 600) begin
      cycle();
      budget++;
    end
    chk({tag, "_arrived"}, 66'(beats_q.size() >= n), 66'd1);
  endtask

  task automatic check_tlp(input int unsigned slot, input logic [63:0] n0,
                           input logic [31:0] base, input logic [31:0] mbase);
    logic [65:0] b, e;
    logic [31:0] a;
    a = (base + slot * 16) << 3;
    for (int j = 0; j < 21; j++) begin
      b = '0;
      if (beats_q.size() > 0) b = beats_q.pop_front();
      if (j == 0)       e = {2'b10, 64'h0108_00FF_4000_0020};
      else if (j == 1)  e = {2'b00, 32'h0, a};
      else if (j < 18)  e = {1'b0, (j == 17), n0 + 64'(j - 2)};
      else if (j == 18) e = {2'b10, 64'h0108_00FF_4000_0002};
      else if (j == 19) e = {2'b00, 32'h0, mbase << 3};
      else              e = {2'b01, 32'h0, 32'((slot + 1) % 16)};
      chk($sformatf("slot%0d_beat%0d", slot, j), b, e);
    end
  endtask

  task automatic check_stats(input logic [31:0] expTlp, input string tag);
`ifdef F2C_STATS_EN
    chk({tag, "_tlpCount"}, 66'(tlpCount_out), 66'(expTlp));
`else
    chk({tag, "_tlpCount_off"}, 66'(tlpCount_out), 66'(0 * expTlp));
    chk({tag, "_stallCount_off"}, 66'(stallCount_out), 66'd0);
`endif
  endtask

  initial begin
    // Reset state
    repeat (3) cycle();
    chk("reset_ctrl", 66'({txValid_out, txSOP_out, txEOP_out, f2cReady_out}), 66'd0);
    chk("reset_data", 66'(txData_out), 66'd0);
    chk("reset_tlpCount", 66'(tlpCount_out), 66'd0);
    chk("reset_stallCount", 66'(stallCount_out), 66'd0);
    reset_in = 1'b0;
    cycle();

    // First TLP pair: slot 0, metrics at QW 16 (byte 0x80), metrics data 1
    wr_reg(F2C_BASE, 32'h0);
    wr_reg(MTR_BASE, 32'd16);
    wr_reg(DMA_ENABLE, 32'd1);
    feedRemain = 16;
    wait_beats(21, "tlp0");
    check_tlp(0, 64'd0, 32'h0, 32'd16);
    check_stats(1, "after_tlp0");

    // Fill the ring with rdPtr held at 0; the 16th buffer must stall
    feedRemain = 240;
    for (int k = 1; k < 15; k++) begin
      wait_beats(21, "fill");
      check_tlp(k, 64'(k * 16), 32'h0, 32'd16);
    end
    repeat (60) cycle();
    chk("full_no_hdr", 66'(beats_q.size()), 66'd0);
    chk("full_txValid", 66'(txValid_out), 66'd0);
    chk("full_ready", 66'(f2cReady_out), 66'd0);
    s1 = stallCount_out;
    repeat (10) cycle();
`ifdef F2C_STATS_EN
    chk("stall_rate", 66'(stallCount_out - s1), 66'd10);
`endif
    check_stats(15, "full");

    // Host frees one slot: slot 15 (0x780), metrics wraps to 0
    wr_reg(F2C_RDPTR, 32'd1);
    wait_beats(21, "slot15");
    check_tlp(15, 64'd240, 32'h0, 32'd16);

    // Random backpressure over 4 TLPs
    wr_reg(F2C_RDPTR, 32'd0);
    bpMode = 1'b1;
    feedRemain = 64;
    for (int k = 0; k < 4; k++) begin
      wait_beats(21, "bp");
      check_tlp(k, 64'(256 + k * 16), 32'h0, 32'd16);
    end
    bpMode = 1'b0;

    // Disable mid-payload: pair completes, then ring pointers flush
    feedRemain = 16;
    wait_beats(7, "mid");
    wr_reg(DMA_ENABLE, 32'd0);
    wait_beats(21, "disable");
    check_tlp(4, 64'd320, 32'h0, 32'd16);
    repeat (5) cycle();
    chk("disabled_txValid", 66'(txValid_out), 66'd0);
    chk("disabled_ready", 66'(f2cReady_out), 66'd0);
    check_stats(0, "flushed");

    // Re-enable from slot 0 with high base addresses; stray channel ignored
    wr_reg(F2C_BASE, 32'h1000_0000);
    wr_reg(DMA_ENABLE, 32'd1);
    wr_reg(7'h7F, 32'd0);
    feedRemain = 16;
    wait_beats(21, "base1");
    check_tlp(0, 64'd336, 32'h1000_0000, 32'd16);
    wr_reg(F2C_BASE, 32'h2000_0000);
    feedRemain = 32;
    wait_beats(21, "wrap1");
    check_tlp(1, 64'd352, 32'h2000_0000, 32'd16);
    wait_beats(21, "wrap2");
    check_tlp(2, 64'd368, 32'h2000_0000, 32'd16);
    cycle();
    check_stats(3, "three");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
